// File: rtl/dff_response_checker.sv
// dff_response_checker: in-hardware scoreboard placed downstream of a single-bit DFF.
// Each checked cycle compares dout against what the DFF should have captured one edge earlier.
module dff_response_checker #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             dut_rst,
   input  logic             din,
   input  logic             dout,
   input  logic             start,
   input  logic [CNT_W-1:0] num_checks,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic             fail_sticky,
   output logic [CNT_W-1:0] first_fail_idx
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARM   = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   // Counters hold at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      if (value == CNT_MAX) begin
         sat_inc = CNT_MAX;
      end else begin
         sat_inc = value + CNT_ONE;
      end
   endfunction

   state_t           state_r;
   state_t           state_s;
   logic             exp_r;
   logic             match_s;
   logic [CNT_W-1:0] remaining_r;
   logic [CNT_W-1:0] idx_r;
   logic [CNT_W-1:0] pass_cnt_r;
   logic [CNT_W-1:0] fail_cnt_r;
   logic             fail_sticky_r;
   logic [CNT_W-1:0] first_fail_idx_r;
   logic             busy_r;
   logic             done_r;

   // An unknown dout must never count as a pass in simulation.
`ifdef SYNTHESIS
   assign match_s = (dout == exp_r);
`else
   assign match_s = (dout === exp_r);
`endif

   // Expected DFF output: the value the DUT should capture at this edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_r <= 1'b0;
      end else begin
         exp_r <= dut_rst ? 1'b0 : din;
      end
   end

   // Next-state logic for the check window.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s = ST_ARM;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ARM: begin
            if (remaining_r == CNT_ZERO) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (remaining_r == CNT_ONE) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_CHECK;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State register; busy/done are registered from the next state so they align with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         busy_r  <= (state_s == ST_ARM) || (state_s == ST_CHECK);
         done_r  <= (state_s == ST_DONE);
      end
   end

   // Window bookkeeping and pass/fail scoring.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         remaining_r      <= CNT_ZERO;
         idx_r            <= CNT_ZERO;
         pass_cnt_r       <= CNT_ZERO;
         fail_cnt_r       <= CNT_ZERO;
         fail_sticky_r    <= 1'b0;
         first_fail_idx_r <= CNT_ZERO;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  remaining_r      <= num_checks;
                  idx_r            <= CNT_ZERO;
                  pass_cnt_r       <= CNT_ZERO;
                  fail_cnt_r       <= CNT_ZERO;
                  fail_sticky_r    <= 1'b0;
                  first_fail_idx_r <= CNT_ZERO;
               end
            end
            ST_CHECK: begin
               if (match_s) begin
                  pass_cnt_r <= sat_inc(pass_cnt_r);
               end else begin
                  fail_cnt_r <= sat_inc(fail_cnt_r);
                  if (!fail_sticky_r) begin
                     fail_sticky_r    <= 1'b1;
                     first_fail_idx_r <= idx_r;
                  end
               end
               idx_r       <= idx_r + CNT_ONE;
               remaining_r <= remaining_r - CNT_ONE;
            end
            default: begin
            end
         endcase
      end
   end

   assign busy           = busy_r;
   assign done           = done_r;
   assign pass_cnt       = pass_cnt_r;
   assign fail_cnt       = fail_cnt_r;
   assign fail_sticky    = fail_sticky_r;
   assign first_fail_idx = first_fail_idx_r;

endmodule

// File: doc/dff_response_checker.md
# dff_response_checker

Synthesizable response checker that sits directly downstream of the `dff` DUT and consumes its output stream. Each cycle it compares `dout` against the value the DFF should have captured on the previous clock edge. It counts passes and failures over a programmed window and records the index of the first mismatch. It gives the environment an in-hardware scoreboard alongside the class-based one.

## Interface
- `CNT_W`, 16: width of `num_checks`, the pass/fail counters and `first_fail_idx`.
- `clk`  in  1  design clock; the same clock that drives the DUT.
- `rst`  in  1  asynchronous, active-high reset of this block.
- `dut_rst`  in  1  reset as driven to the DUT; the DUT clears `dout` to 0 synchronously when it is high.
- `din`  in  1  DUT data input, as driven to the DUT.
- `dout`  in  1  DUT data output.
- `start`  in  1  single-cycle pulse that begins a check window; honoured only in IDLE.
- `num_checks`  in  CNT_W  number of comparisons to perform; sampled when `start` is accepted.
- `busy`  out  1  high in ARM and CHECK.
- `done`  out  1  one-cycle pulse, high in DONE.
- `pass_cnt`  out  CNT_W  comparisons that matched.
- `fail_cnt`  out  CNT_W  comparisons that mismatched.
- `fail_sticky`  out  1  set on the first mismatch of a window.
- `first_fail_idx`  out  CNT_W  zero-based index of the first mismatching comparison; valid only when `fail_sticky` is 1.

## Operation
- Expected-value model:
  - `exp` is a register loaded every cycle with `dut_rst ? 0 : din`.
  - The comparison in cycle k uses the `exp` value loaded at edge k-1.
- States are IDLE, ARM, CHECK and DONE.
- IDLE:
  - On `start`=1, latch `num_checks` into `remaining`.
  - Clear `pass_cnt`, `fail_cnt`, `fail_sticky`, `first_fail_idx` and the index counter `idx`.
  - Go to ARM.
- ARM:
  - Lasts one cycle and performs no comparison, so `exp` is primed with valid history.
  - If `remaining`=0, go to DONE; otherwise go to CHECK.
- CHECK, every cycle:
  - If `dout == exp`, increment `pass_cnt`; otherwise increment `fail_cnt`.
  - On a mismatch while `fail_sticky`=0, set `fail_sticky` and load `first_fail_idx` with `idx`.
  - Increment `idx` and decrement `remaining`.
  - Leave for DONE in the cycle where `remaining` reaches 0.
- DONE: assert `done` for one cycle, then return to IDLE.
- Arithmetic and width rules:
  - `pass_cnt` and `fail_cnt` saturate at 2^CNT_W−1.
  - `idx` wraps modulo 2^CNT_W; it cannot exceed `num_checks`−1.
  - `pass_cnt + fail_cnt == num_checks` at DONE.
- Results persist after DONE until the next accepted `start`.
- `start` in ARM, CHECK or DONE is ignored; nothing is queued.
- `dut_rst` high during a window is legal. The DUT output must then read 0 on the following cycle, and the checker does not pause.
- X/Z on `dout` counts as a mismatch: the comparison uses `===` semantics in simulation, and a plain compare in synthesis.

## Timing
- Reset (`rst`=1, asynchronous):
  - State goes to IDLE.
  - `busy`=0, `done`=0, `pass_cnt`=0, `fail_cnt`=0, `fail_sticky`=0, `first_fail_idx`=0, `exp`=0.
  - Reset deasserts synchronously to `clk` externally.
- `rst` asserted mid-window aborts the window immediately. All outputs take their reset values and no `done` pulse is produced.
- Cycle sequence for an accepted `start` at edge t, with N = `num_checks`:
  - `busy` rises after edge t (ARM).
  - Comparisons happen in the cycles after edges t+1 … t+N.
  - `done` is high in the cycle after edge t+N+1, and `busy` is 0 in that cycle.
- N=0: ARM is followed immediately by DONE, so `done` appears 2 cycles after `start`, with all counts 0.
- Outputs are registered; no combinational path from inputs to outputs.
- Back-to-back windows: `start` may be asserted in the first IDLE cycle after DONE.

## Test plan
- Correct DFF, N=30 random `din`, `dut_rst`=0 → `done` 32 cycles after `start`, `pass_cnt`=30, `fail_cnt`=0, `fail_sticky`=0.
- Force `dout` inverted on comparison index 5 only, N=10 → `fail_cnt`=1, `pass_cnt`=9, `fail_sticky`=1, `first_fail_idx`=5.
- Pulse `dut_rst` for 3 cycles mid-window while `din`=1, correct DUT → no failures; mismatches are reported only if `dout` stays 1 after a `dut_rst` cycle.
- N=0 → `done` 2 cycles after `start`, all counts 0. A second `start` issued during a busy N=8 window is ignored, and counts total 8.
- CNT_W=4, N=15, DUT with `dout` stuck at 0 and random `din` → `fail_cnt` + `pass_cnt` = 15. Then N=15 with `dout` stuck at 1 and `din`=0 → `fail_cnt` saturates at 15 without wrapping.
- Assert `rst` in the middle of a CHECK window → all outputs 0 asynchronously, no `done` pulse. A new `start` after release runs a clean window.
